// File: rtl/rv32_pkg.sv
// Shared RV32I control types: datapath select enums, FSM states, opcode/funct constants
// and the decoded-control bundle used by rv32_mc_ctrl.
package rv32_pkg;
  typedef enum logic [0:0] {PC_PC4 = 1'b0, PC_ALU = 1'b1} PCSel_t;
  typedef enum logic [2:0] {Imm_I, Imm_S, Imm_B, Imm_U, Imm_J} ImmSel_t;
  typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
                            ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI} ALUSel_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} WBSel_t;
  typedef enum logic [0:0] {A_RS1, A_PC} ASel_t;
  typedef enum logic [0:0] {B_RS2, B_IMM} BSel_t;
  typedef enum logic [0:0] {ADDR_PC, ADDR_ALU} AddrSel_t;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, FAULT} ctrl_state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_LSW     = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_BLTU    = 3'b110;
  localparam logic [2:0] F3_BGEU    = 3'b111;
  localparam logic       F7B5_ALT   = 1'b1;

  typedef struct packed {
    ImmSel_t imm;
    ALUSel_t alu;
    ASel_t   a;
    BSel_t   b;
    WBSel_t  wb;
    logic    is_load;
    logic    is_store;
    logic    is_branch;
    logic    is_jump;
  } ctrl_dec_t;

  // alt only matters for funct3 000 (SUB) and 101 (SRA)
  function automatic ALUSel_t f3_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/rv32_ctrl_decode.sv
// Combinational RV32I opcode/funct decode: datapath selects, illegal flag, branch outcome.
module rv32_ctrl_decode
  import rv32_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_br_eq,
  input  logic       i_br_lt,
  input  logic       i_br_ltu,
  output ctrl_dec_t  o_dec,
  output logic       o_illegal,
  output logic       o_br_taken
);
  always_comb begin
    o_dec.imm       = Imm_I;
    o_dec.alu       = ALU_ADD;
    o_dec.a         = A_RS1;
    o_dec.b         = B_IMM;
    o_dec.wb        = WB_ALU;
    o_dec.is_load   = 1'b0;
    o_dec.is_store  = 1'b0;
    o_dec.is_branch = 1'b0;
    o_dec.is_jump   = 1'b0;
    o_illegal       = 1'b0;
    case (i_opcode)
      OP_R: begin
        o_dec.b   = B_RS2;
        o_dec.alu = f3_alu(i_funct3, i_funct7b5);
        o_illegal = (i_funct7b5 == F7B5_ALT) && (i_funct3 != F3_ADD_SUB) && (i_funct3 != F3_SRL_SRA);
      end
      OP_IMM: begin
        // funct7b5 is immediate data except on shifts, where it picks SRAI
        o_dec.alu = f3_alu(i_funct3, (i_funct3 == F3_SRL_SRA) && (i_funct7b5 == F7B5_ALT));
        o_illegal = (i_funct3 == F3_SLL) && (i_funct7b5 == F7B5_ALT);
      end
      OP_LOAD: begin
        o_dec.is_load = 1'b1;
        o_dec.wb      = WB_MEM;
        o_illegal     = (i_funct3 != F3_LSW);
      end
      OP_STORE: begin
        o_dec.imm      = Imm_S;
        o_dec.is_store = 1'b1;
        o_illegal      = (i_funct3 != F3_LSW);
      end
      OP_LUI: begin
        o_dec.imm = Imm_U;
        o_dec.alu = ALU_LUI;
      end
      OP_AUIPC: begin
        o_dec.imm = Imm_U;
        o_dec.a   = A_PC;
      end
      OP_JAL: begin
        o_dec.imm     = Imm_J;
        o_dec.a       = A_PC;
        o_dec.wb      = WB_PC4;
        o_dec.is_jump = 1'b1;
      end
      OP_JALR: begin
        o_dec.wb      = WB_PC4;
        o_dec.is_jump = 1'b1;
      end
      OP_BRANCH: begin
        o_dec.imm       = Imm_B;
        o_dec.a         = A_PC;
        o_dec.is_branch = 1'b1;
        o_illegal       = (i_funct3 == 3'b010) || (i_funct3 == 3'b011);
      end
      default: o_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (i_funct3)
      F3_BEQ:  o_br_taken = i_br_eq;
      F3_BNE:  o_br_taken = !i_br_eq;
      F3_BLT:  o_br_taken = i_br_lt;
      F3_BGE:  o_br_taken = !i_br_lt;
      F3_BLTU: o_br_taken = i_br_ltu;
      F3_BGEU: o_br_taken = !i_br_ltu;
      default: o_br_taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle RV32I control FSM with memory timeout and sticky fault.
// Optional cycle/instret counters are built when RV32_CTRL_PERF_EN is defined.
module rv32_mc_ctrl
  import rv32_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       ir_opcode,
  input  logic [2:0]       ir_funct3,
  input  logic             ir_funct7b5,
  input  logic             br_eq,
  input  logic             br_lt,
  input  logic             br_ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output PCSel_t           pc_sel,
  output ImmSel_t          imm_sel,
  output ALUSel_t          alu_sel,
  output logic             a_sel,
  output logic             b_sel,
  output logic             reg_we,
  output WBSel_t           wb_sel,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  ctrl_state_t       r_state, w_next;
  ctrl_dec_t         w_dec, r_dec;
  logic              w_illegal, w_taken, w_stall, w_timeout;
  logic [WAIT_W-1:0] r_wait;

  rv32_ctrl_decode u_dec (
    .i_opcode   (ir_opcode),
    .i_funct3   (ir_funct3),
    .i_funct7b5 (ir_funct7b5),
    .i_br_eq    (br_eq),
    .i_br_lt    (br_lt),
    .i_br_ltu   (br_ltu),
    .o_dec      (w_dec),
    .o_illegal  (w_illegal),
    .o_br_taken (w_taken)
  );

  // rst gates the request combinationally so it drops without waiting for a clock
  assign mem_req   = ((r_state == FETCH) || (r_state == MEM)) && !rst;
  assign w_stall   = mem_req && !mem_ready;
  assign w_timeout = (MAX_WAIT > 0) && w_stall && (r_wait == WAIT_W'(MAX_WAIT - 1));

  always_comb begin
    w_next   = r_state;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PC4;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    addr_sel = ADDR_PC;
    case (r_state)
      FETCH: begin
        if (w_timeout)                 w_next = FAULT;
        else if (mem_req && mem_ready) begin
          ir_we  = 1'b1;
          w_next = DECODE;
        end
      end
      DECODE: w_next = w_illegal ? FAULT : EXEC;
      EXEC: begin
        if (r_dec.is_branch) begin
          pc_we  = 1'b1;
          pc_sel = w_taken ? PC_ALU : PC_PC4;
          w_next = FETCH;
        end else if (r_dec.is_load || r_dec.is_store) begin
          w_next = MEM;
        end else begin
          w_next = WB;
        end
      end
      MEM: begin
        addr_sel = ADDR_ALU;
        mem_we   = r_dec.is_store;
        if (w_timeout)                 w_next = FAULT;
        else if (mem_req && mem_ready) begin
          pc_we  = r_dec.is_store;
          w_next = r_dec.is_store ? FETCH : WB;
        end
      end
      WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        pc_sel = r_dec.is_jump ? PC_ALU : PC_PC4;
        w_next = FETCH;
      end
      FAULT:   w_next = FAULT;
      default: w_next = FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
      r_wait  <= '0;
      r_dec   <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_stall && (w_next == r_state)) ? r_wait + WAIT_W'(1) : '0;
      // selects latch once per instruction and hold through MEM/WB
      if (r_state == DECODE) r_dec <= w_dec;
    end
  end

  assign fault   = (r_state == FAULT);
  assign imm_sel = r_dec.imm;
  assign alu_sel = r_dec.alu;
  assign a_sel   = r_dec.a;
  assign b_sel   = r_dec.b;
  assign wb_sel  = r_dec.wb;

`ifdef RV32_CTRL_PERF_EN
  logic [CNT_W-1:0] r_cycle, r_instret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else if (r_state != FAULT) begin
      r_cycle <= r_cycle + CNT_W'(1);
      if (pc_we) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign cycle_cnt   = r_cycle;
  assign instret_cnt = r_instret;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Self-checking bench for rv32_mc_ctrl: per-instruction expected cycle schedules built from
// the ISA rules, directed corner cases plus randomized instruction/stall mixes.
module tb_rv32_mc_ctrl;
  import rv32_pkg::*;

  localparam int MAXW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  opc = '0;
  logic [2:0]  f3 = '0;
  logic        f7 = 1'b0, beq = 1'b0, blt = 1'b0, bltu = 1'b0, rdy = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, a_sel, b_sel, reg_we, fault;
  PCSel_t      pc_sel;
  ImmSel_t     imm_sel;
  ALUSel_t     alu_sel;
  WBSel_t      wb_sel;
  logic [31:0] cycle_cnt, instret_cnt;

  rv32_mc_ctrl #(.MAX_WAIT(MAXW), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ir_opcode(opc), .ir_funct3(f3), .ir_funct7b5(f7),
    .br_eq(beq), .br_lt(blt), .br_ltu(bltu), .mem_ready(rdy),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_sel(alu_sel),
    .a_sel(a_sel), .b_sel(b_sel), .reg_we(reg_we), .wb_sel(wb_sel), .fault(fault),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef enum {C_R, C_I, C_LD, C_ST, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_BAD} cls_t;

  // one entry per clock: input to drive and the outputs expected in that cycle
  typedef struct {
    logic rdy, mreq, mwe, addr, irwe, pcwe, pcsel, regwe, flt, selchk;
  } cyc_t;

  cyc_t    sched[$];
  int      errs = 0, checks = 0;
  int      m_cyc = 0, m_ret = 0;
  cls_t    cur_c;
  ImmSel_t e_imm;
  ALUSel_t e_alu;
  WBSel_t  e_wb;
  logic    e_a, e_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cls_t classify(input logic [6:0] o);
    case (o)
      7'h33: return C_R;     7'h13: return C_I;    7'h03: return C_LD;
      7'h23: return C_ST;    7'h37: return C_LUI;  7'h17: return C_AUIPC;
      7'h6f: return C_JAL;   7'h67: return C_JALR; 7'h63: return C_BR;
      default: return C_BAD;
    endcase
  endfunction

  function automatic bit legal(input cls_t c, input logic [2:0] f, input logic s7);
    case (c)
      C_BAD:      return 1'b0;
      C_LD, C_ST: return f == 3'd2;
      C_BR:       return !(f == 3'd2 || f == 3'd3);
      C_R:        return !(s7 && f != 3'd0 && f != 3'd5);
      C_I:        return !(f == 3'd1 && s7);
      default:    return 1'b1;
    endcase
  endfunction

  function automatic ALUSel_t alu_of(input cls_t c, input logic [2:0] f, input logic s7);
    if (c == C_LUI) return ALU_LUI;
    if (c != C_R && c != C_I) return ALU_ADD;
    case (f)
      3'd0: return (c == C_R && s7) ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return s7 ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic ImmSel_t imm_of(input cls_t c);
    case (c)
      C_ST:          return Imm_S;
      C_LUI, C_AUIPC: return Imm_U;
      C_JAL:         return Imm_J;
      C_BR:          return Imm_B;
      default:       return Imm_I;
    endcase
  endfunction

  function automatic bit taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic cyc_t mk(input logic r, mreq, mwe, addr, irwe, pcwe, pcsel, regwe, flt, sc);
    cyc_t c;
    c.rdy = r; c.mreq = mreq; c.mwe = mwe; c.addr = addr; c.irwe = irwe;
    c.pcwe = pcwe; c.pcsel = pcsel; c.regwe = regwe; c.flt = flt; c.selchk = sc;
    return c;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // d un-acknowledged request cycles; a wait of MAXW or more ends in timeout
  task automatic push_wait(input int d, input logic mwe, input logic addr, input logic sc, output bit to);
    int n;
    n = (d >= MAXW) ? MAXW : d;
    for (int i = 0; i < n; i++) sched.push_back(mk(0, 1, mwe, addr, 0, 0, 0, 0, 0, sc));
    to = (d >= MAXW);
  endtask

  task automatic play();
    foreach (sched[i]) begin
      rdy = sched[i].rdy;
      @(negedge clk);
      chk("mem_req", mem_req, sched[i].mreq);
      chk("mem_we", mem_we, sched[i].mwe);
      if (sched[i].mreq) chk("addr_sel", addr_sel, sched[i].addr);
      chk("ir_we", ir_we, sched[i].irwe);
      chk("pc_we", pc_we, sched[i].pcwe);
      if (sched[i].pcwe) chk("pc_sel", pc_sel, sched[i].pcsel);
      chk("reg_we", reg_we, sched[i].regwe);
      if (sched[i].regwe) chk("wb_sel", wb_sel, e_wb);
      chk("fault", fault, sched[i].flt);
      if (sched[i].selchk) begin
        if (cur_c != C_R) chk("imm_sel", imm_sel, e_imm);
        chk("alu_sel", alu_sel, e_alu);
        chk("a_sel", a_sel, e_a);
        chk("b_sel", b_sel, e_b);
      end
`ifdef RV32_CTRL_PERF_EN
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("instret_cnt", instret_cnt, m_ret);
`else
      chk("cycle_cnt", cycle_cnt, 0);
      chk("instret_cnt", instret_cnt, 0);
`endif
      @(posedge clk);
      #1;
      if (!sched[i].flt) m_cyc++;
      if (sched[i].pcwe) m_ret++;
    end
    sched.delete();
  endtask

  // asserted mid-cycle so the asynchronous drop of mem_req is observable
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst mem_req", mem_req, 0);
    chk("rst fault", fault, 0);
    chk("rst enables", {ir_we, pc_we, reg_we, mem_we}, 0);
    chk("rst selects", {pc_sel, imm_sel, alu_sel, a_sel, b_sel, wb_sel, addr_sel}, 0);
    chk("rst counters", {cycle_cnt, instret_cnt}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cyc = 0;
    m_ret = 0;
  endtask

  task automatic run(input logic [6:0] o, input logic [2:0] f, input logic s7,
                     input logic [31:0] ra, input logic [31:0] rb2, input int df, input int dm);
    cls_t c;
    bit   to;
    c = classify(o);
    cur_c = c;
    e_alu = alu_of(c, f, s7);
    e_imm = imm_of(c);
    e_a   = (c == C_AUIPC || c == C_JAL || c == C_BR);
    e_b   = (c != C_R);
    e_wb  = (c == C_LD) ? WB_MEM : (c == C_JAL || c == C_JALR) ? WB_PC4 : WB_ALU;
    opc = o; f3 = f; f7 = s7;
    beq = (ra == rb2); blt = ($signed(ra) < $signed(rb2)); bltu = (ra < rb2);
    push_wait(df, 0, 0, 0, to);
    if (!to) begin
      sched.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      sched.push_back(mk(rb(), 0, 0, 0, 0, 0, 0, 0, 0, 0));
      if (!legal(c, f, s7)) to = 1;
      else if (c == C_BR) begin
        sched.push_back(mk(rb(), 0, 0, 0, 0, 1, taken(f, ra, rb2), 0, 0, 1));
      end else begin
        sched.push_back(mk(rb(), 0, 0, 0, 0, 0, 0, 0, 0, 1));
        if (c == C_LD || c == C_ST) begin
          push_wait(dm, c == C_ST, 1, 1, to);
          if (!to) sched.push_back(mk(1, 1, c == C_ST, 1, 0, c == C_ST, 0, 0, 0, 1));
        end
        if (!to && c != C_ST)
          sched.push_back(mk(rb(), 0, 0, 0, 0, 1, (c == C_JAL || c == C_JALR), 1, 0, 1));
      end
    end
    if (to) for (int i = 0; i < 12; i++) sched.push_back(mk(rb(), 0, 0, 0, 0, 0, 0, 0, 1, 0));
    play();
    if (to) do_reset();
  endtask

  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h7f};

  initial begin
    #2;
    do_reset();
    run(7'h33, 3'd0, 1'b0, 1, 2, 0, 0);          // ADD, minimum latency
    run(7'h33, 3'd0, 1'b1, 1, 2, 0, 0);          // SUB
    run(7'h03, 3'd2, 1'b0, 0, 0, 0, 3);          // LW, three stall cycles in MEM
    run(7'h23, 3'd2, 1'b0, 0, 0, 1, 0);          // SW
    run(7'h63, 3'd1, 1'b0, 5, 7, 0, 0);          // BNE taken
    run(7'h63, 3'd1, 1'b0, 9, 9, 0, 0);          // BNE not taken
    run(7'h63, 3'd6, 1'b0, 1, 32'hffff_fff0, 0, 0); // BLTU taken
    run(7'h63, 3'd4, 1'b0, 32'hffff_fff0, 1, 0, 0); // BLT taken on signed
    run(7'h13, 3'd5, 1'b1, 0, 0, 0, 0);          // SRAI
    run(7'h67, 3'd0, 1'b0, 0, 0, 0, 0);          // JALR
    run(7'h6f, 3'd3, 1'b1, 0, 0, 0, 0);          // JAL
    run(7'h37, 3'd0, 1'b0, 0, 0, 0, 0);          // LUI
    run(7'h33, 3'd0, 1'b0, 0, 0, MAXW - 1, 0);   // acked on the last allowed cycle
    run(7'h03, 3'd2, 1'b0, 0, 0, 0, MAXW - 1);
    run(7'h7f, 3'd0, 1'b0, 0, 0, 0, 0);          // unknown opcode
    run(7'h03, 3'd0, 1'b0, 0, 0, 0, 0);          // LB not supported
    run(7'h13, 3'd1, 1'b1, 0, 0, 0, 0);          // SLLI with funct7b5
    run(7'h63, 3'd2, 1'b0, 0, 0, 0, 0);          // reserved branch funct3
    run(7'h33, 3'd0, 1'b0, 0, 0, MAXW, 0);       // fetch timeout
    run(7'h23, 3'd2, 1'b0, 0, 0, 2, MAXW + 3);   // store timeout in MEM
    for (int i = 0; i < 5; i++) sched.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    play();
    do_reset();                                  // reset in the middle of a fetch wait
    run(7'h33, 3'd7, 1'b0, 0, 0, 0, 0);
    for (int n = 0; n < 60; n++) begin
      logic [6:0]  o;
      logic [2:0]  f;
      logic [31:0] a, b;
      o = ops[$urandom_range(0, 9)];
      if (o == 7'h7f) o = 7'($urandom);
      f = 3'($urandom);
      if ((o == 7'h03 || o == 7'h23) && $urandom_range(0, 3) != 0) f = 3'd2;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run(o, f, rb(), a, b, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rv32_mc_ctrl.md
Name: rv32_mc_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences one shared datapath (PC/IR registers, regfile, immediate generator, ALU, branch comparator) and one unified instruction/data memory port through fetch, decode, execute, memory and writeback. All datapath selects are driven from the rv32_pkg enums. Sits between the datapath and the memory request/ready interface.

Parameters:
MAX_WAIT, 16, number of cycles a memory request may stay un-acknowledged before FAULT; 0 disables the timeout
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
ir_opcode  in  7  IR[6:0]
ir_funct3  in  3  IR[14:12]
ir_funct7b5  in  1  IR[30]
br_eq  in  1  rs1==rs2
br_lt  in  1  rs1<rs2 signed
br_ltu  in  1  rs1<rs2 unsigned
mem_ready  in  1  memory accepts/completes current request this cycle
mem_req  out  1  memory request valid
mem_we  out  1  1=store
addr_sel  out  1  0=PC, 1=ALU result as memory address
ir_we  out  1  load IR from memory read data
pc_we  out  1  update PC
pc_sel  out  PCSel_t  PC_PC4 / PC_ALU
imm_sel  out  ImmSel_t  immediate format
alu_sel  out  ALUSel_t  ALU operation
a_sel  out  1  0=rs1, 1=PC
b_sel  out  1  0=rs2, 1=immediate
reg_we  out  1  regfile write enable
wb_sel  out  WBSel_t  writeback source
fault  out  1  sticky illegal-instruction/timeout flag
cycle_cnt  out  CNT_W  cycles since reset (see Optional Feature)
instret_cnt  out  CNT_W  retired instructions (see Optional Feature)

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, FAULT. Reset: state=FETCH, wait counter=0, all enables/mem_req/fault=0, selects=0, counters=0.
- FETCH: mem_req=1, mem_we=0, addr_sel=0. On mem_ready: ir_we=1 in the same cycle, next state DECODE. mem_ready outside a request is ignored.
- DECODE: one cycle, no enables. Illegal go to FAULT: unknown opcode; load/store funct3≠F3_LSW; branch funct3 010/011; R funct7b5=1 with funct3∉{ADD_SUB,SRL_SRA}; SLLI with funct7b5=1. Otherwise go to EXEC.
- EXEC selects: R: b_sel=0, alu_sel from funct3, with funct7b5 choosing SUB/SRA. I_ALU: Imm_I, b_sel=1, SRAI when funct7b5. LOAD: Imm_I, ADD. STORE: Imm_S, ADD. LUI: Imm_U, ALU_LUI. AUIPC: Imm_U, a_sel=1, ADD. JAL: Imm_J, a_sel=1, ADD. JALR: Imm_I, ADD. B: Imm_B, a_sel=1, b_sel=1, ADD.
- EXEC next state: B sets pc_we=1 and pc_sel=PC_ALU if taken (BEQ eq, BNE !eq, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu), else PC_PC4, then goes to FETCH. LOAD/STORE go to MEM. All others go to WB.
- Selects are held constant from EXEC through MEM/WB of the same instruction.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for store. On mem_ready: store sets pc_we=1, PC_PC4, then goes to FETCH; load goes to WB.
- WB: reg_we=1 for exactly one cycle. wb_sel is WB_MEM for load, WB_PC4 for JAL/JALR, else WB_ALU. pc_we=1 with pc_sel=PC_ALU for JAL/JALR, else PC_PC4. Then goes to FETCH.
- pc_we is asserted exactly once per retired instruction. Retirement happens on the pc_we cycle.
- Timeout: counter increments each cycle with mem_req && !mem_ready and clears on mem_ready or on leaving FETCH/MEM. When it reaches MAX_WAIT (MAX_WAIT>0), the next state is FAULT and no ir_we/pc_we is issued.
- FAULT: fault=1, all enables and mem_req=0. Terminal until rst.
- rst asserted mid-request drops mem_req asynchronously. After release, the first cycle is FETCH with mem_req=1.
- Minimum latency: ALU op 4 cycles, load 5, store 4, branch 3 (mem_ready=1).

Optional Feature:
RV32_CTRL_PERF_EN. When defined: cycle_cnt increments every non-reset cycle, and instret_cnt increments on each pc_we. Both wrap modulo 2^CNT_W and freeze in FAULT. When undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Add to rv32_pkg: ctrl_state_t enum (FETCH..FAULT), ASel/BSel/AddrSel 1-bit enums, and F7B5_ALT constant.
- Sub-module rv32_ctrl_decode: combinational opcode/funct decode producing selects, an illegal flag and a branch-taken flag. The FSM, timeout counter and perf counters stay in rv32_mc_ctrl.

Test Plan:
- ADD (R, funct7b5=0) with mem_ready=1: FETCH-DECODE-EXEC-WB. The WB cycle has reg_we=1, wb_sel=WB_ALU, pc_we=1, PC_PC4, alu_sel=ALU_ADD. Total 4 cycles. With the macro defined, instret_cnt goes 0→1.
- LW with mem_ready delayed 3 cycles in MEM: mem_req=1, addr_sel=1, mem_we=0 for 4 cycles. Then WB with wb_sel=WB_MEM and reg_we=1.
- BNE with br_eq=0 gives pc_we=1, PC_ALU in EXEC and no reg_we. BNE with br_eq=1 gives PC_PC4. BLTU with br_ltu=1 is taken.
- JALR: WB cycle shows reg_we=1, wb_sel=WB_PC4, pc_sel=PC_ALU, imm_sel=Imm_I.
- Opcode 7'b1111111, or a load with funct3=000: FAULT after DECODE, fault=1. All enables stay 0 for 10+ cycles until rst.
- MAX_WAIT=16 with mem_ready held 0 in FETCH: FAULT entered 16 cycles after mem_req rises, with no ir_we. Asserting rst mid-wait drops mem_req immediately, and fetch resumes after release.
